// File: rtl/aes_pkg.sv
// Shared AES constants, types and byte-level helpers for the AES-256 key schedule.
// S-box is computed as GF(2^8) inverse followed by the affine map.
package aes_pkg;

    localparam int NK     = 8;
    localparam int NR     = 14;
    localparam int NUM_RK = NR + 1;

    typedef logic [31:0]       word_t;
    typedef logic [127:0]      rkey_t;
    typedef logic [32*NK-1:0]  key256_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } ks_state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] a;
        a = gf_inv(x);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes256_key_schedule_kexp.sv
// One AES-256 key expansion step: eight previous words in, eight next words out.
// Purely combinational; cnt selects Rcon (cnt=1 -> 0x01000000).
module aes256_key_schedule_kexp
    import aes_pkg::*;
(
    input  key256_t    cur,
    input  logic [2:0] cnt,
    output key256_t    nxt
);

    word_t      w [NK];
    word_t      n [NK];
    logic [7:0] rcon;

    always_comb begin
        rcon = 8'h01 << (cnt - 3'd1);
        for (int i = 0; i < NK; i++) begin
            w[i] = cur[32*(NK-1-i) +: 32];
        end
        n[0] = w[0] ^ sub_word(rot_word(w[7])) ^ {rcon, 24'h000000};
        for (int i = 1; i < 4; i++) begin
            n[i] = w[i] ^ n[i-1];
        end
        // AES-256 only: the middle word gets an extra SubWord without rotation or Rcon.
        n[4] = w[4] ^ sub_word(n[3]);
        for (int i = 5; i < NK; i++) begin
            n[i] = w[i] ^ n[i-1];
        end
        nxt = '0;
        for (int i = 0; i < NK; i++) begin
            nxt[32*(NK-1-i) +: 32] = n[i];
        end
    end

endmodule

// File: rtl/aes256_key_schedule.sv
// Sequential AES-256 key schedule: one expansion step per clock, 15 round keys in flops.
// Ready 7 cycles after an accepted start; registered read port returns 0 unless ready.
module aes256_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    output logic         busy,
    output logic         key_ready,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    localparam logic [2:0] LAST_STEP = 3'(NUM_RK / 2);

    ks_state_t  state;
    ks_state_t  state_nxt;
    key256_t    cur;
    key256_t    nxt;
    logic [2:0] cnt;
    logic       load;
    logic       step;
    logic       last;
    rkey_t      rk [NUM_RK];

    aes256_key_schedule_kexp u_kexp (
        .cur (cur),
        .cnt (cnt),
        .nxt (nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (cnt == LAST_STEP) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            key_ready <= 1'b0;
            cnt       <= 3'd0;
        end else if (load) begin
            cur       <= key;
            cnt       <= 3'd1;
            busy      <= 1'b1;
            key_ready <= 1'b0;
        end else if (step) begin
            if (last) begin
                busy      <= 1'b0;
                key_ready <= 1'b1;
            end else begin
                cur <= nxt;
                cnt <= cnt + 3'd1;
            end
        end
    end

    // Round keys are deliberately not reset; key_ready gating hides stale contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (load) begin
                rk[0] <= key[255:128];
                rk[1] <= key[127:0];
            end else if (step) begin
                rk[{cnt, 1'b0}] <= nxt[255:128];
                if (!last) rk[{cnt, 1'b1}] <= nxt[127:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                  rd_key <= '0;
        else if (key_ready && rd_idx <= 4'(NR))   rd_key <= rk[rd_idx];
        else                                      rd_key <= '0;
    end

endmodule

// File: tb/tb_aes256_key_schedule.sv
// Directed bench for aes256_key_schedule against FIPS-197 key expansion vectors.
// Covers reset, latency, reverse read sweep, ignored start, mid-expansion reset and reload.
module tb_aes256_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] key;
    logic         busy;
    logic         key_ready;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int vectors    = 0;
    int miscompares = 0;
    int lat;

    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic [127:0] c3 [15] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'h101112131415161718191a1b1c1d1e1f,
        128'ha573c29fa176c498a97fce93a572c09c,
        128'h1651a8cd0244beda1a5da4c10640bade,
        128'hae87dff00ff11b68a68ed5fb03fc1567,
        128'h6de1f1486fa54f9275f8eb5373b8518d,
        128'hc656827fc9a799176f294cec6cd5598b,
        128'h3de23a75524775e727bf9eb45407cf39,
        128'h0bdc905fc27b0948ad5245a4c1871c2f,
        128'h45f5a66017b2d387300d4d33640a820a,
        128'h7ccff71cbeb4fe5413e6bbf0d261a7df,
        128'hf01afafee7a82979d7a5644ab3afe640,
        128'h2541fe719bf500258813bbd55a721c0a,
        128'h4e5a6699a9f24fe07e572baacdf8cdea,
        128'h24fc79ccbf0979e9371ac23c6d68de36
    };

    localparam logic [127:0] A3_RK0  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] A3_RK1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] A3_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

    aes256_key_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .busy      (busy),
        .key_ready (key_ready),
        .rd_idx    (rd_idx),
        .rd_key    (rd_key)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Steps until key_ready; lat is the edge index after the load edge (E0), 0 on timeout.
    task automatic wait_ready(input int already, output int lat_o);
        lat_o = 0;
        for (int i = 1; i <= 20 && lat_o == 0; i++) begin
            tick();
            if (key_ready === 1'b1) lat_o = already + i;
        end
    endtask

    task automatic read(input logic [3:0] idx);
        rd_idx = idx;
        tick();
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        key    = '0;
        rd_idx = 4'd0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", 256'(busy), 256'(0));
        check("reset_ready", 256'(key_ready), 256'(0));
        check("reset_rdkey", 256'(rd_key), 256'(0));

        // FIPS-197 C.3 key
        key   = KEY_C3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("c3_busy_e0", 256'(busy), 256'(1));
        check("c3_ready_e0", 256'(key_ready), 256'(0));
        tick();
        check("c3_rdkey_expand", 256'(rd_key), 256'(0));
        wait_ready(1, lat);
        check("c3_latency", 256'(lat), 256'(7));
        check("c3_busy_done", 256'(busy), 256'(0));

        // Reverse sweep on consecutive cycles, then the out-of-range index
        for (int i = 14; i >= 0; i--) begin
            read(4'(i));
            check($sformatf("c3_rk%0d", i), 256'(rd_key), 256'(c3[i]));
        end
        read(4'd15);
        check("c3_idx15", 256'(rd_key), 256'(0));

        // Reload from DONE with the A.3 key
        rd_idx = 4'd2;
        key    = KEY_A3;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("reload_ready_drop", 256'(key_ready), 256'(0));
        tick();
        check("reload_rdkey_zero", 256'(rd_key), 256'(0));
        wait_ready(1, lat);
        check("reload_latency", 256'(lat), 256'(7));
        read(4'd0);
        check("a3_rk0", 256'(rd_key), 256'(A3_RK0));
        read(4'd2);
        check("a3_rk2", 256'(rd_key), 256'(A3_RK2));
        read(4'd14);
        check("a3_rk14", 256'(rd_key), 256'(A3_RK14));

        // start during EXPAND is ignored
        key   = KEY_C3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        key   = KEY_A3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ignored_start_busy", 256'(busy), 256'(1));
        wait_ready(3, lat);
        check("ignored_start_latency", 256'(lat), 256'(7));
        read(4'd0);
        check("ignored_start_rk0", 256'(rd_key), 256'(c3[0]));
        read(4'd2);
        check("ignored_start_rk2", 256'(rd_key), 256'(c3[2]));
        read(4'd14);
        check("ignored_start_rk14", 256'(rd_key), 256'(c3[14]));

        // rst at cycle 4 of EXPAND aborts
        key   = KEY_A3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_ready", 256'(key_ready), 256'(0));
        check("abort_rdkey", 256'(rd_key), 256'(0));
        read(4'd5);
        check("abort_rdkey_idx5", 256'(rd_key), 256'(0));
        tick();
        tick();
        tick();
        tick();
        check("abort_ready_stays_low", 256'(key_ready), 256'(0));

        // start together with rst: rst wins
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("start_rst_busy", 256'(busy), 256'(0));

        // Fresh load after the abort completes normally
        key   = KEY_A3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_ready(0, lat);
        check("after_abort_latency", 256'(lat), 256'(7));
        read(4'd1);
        check("after_abort_rk1", 256'(rd_key), 256'(A3_RK1));
        read(4'd14);
        check("after_abort_rk14", 256'(rd_key), 256'(A3_RK14));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
